// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the binary-convolution datapath.
// Imported by every stage that needs the row geometry or the controller states.
package conv_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int COL_W  = 4;

    localparam logic [DATA_W-1:0] END_MARKER = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10,
        DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/output_row_packer.sv
// Packs one result pixel per cycle into a row word and issues one SRAM write per row,
// with end-of-image flush and busy/done handshaking toward the controller.
module output_row_packer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [COL_W-1:0]  last_col,
    input  logic              px_valid,
    input  logic              px_neg,
    input  logic [COL_W-1:0]  px_col,
    input  logic [ADDR_W-1:0] px_waddr,
    input  logic              flush,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rows_written,
    output logic              col_err
);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  last_col_q;
    logic [DATA_W-1:0] accum_q;
    logic [DATA_W-1:0] accum_merged;
    logic [DATA_W-1:0] col_mask;
    logic              row_open_q;
    logic [ADDR_W-1:0] last_addr_q;

    logic              active;
    logic              px_accept;
    logic              px_bad;
    logic              row_done;
    logic              drain_write;
    logic              issue_write;
    logic [ADDR_W-1:0] write_addr;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        state_d = state_q;
        if (start) begin
            state_d = ACTIVE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ACTIVE:  if (flush) state_d = DRAIN;
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // ---------------- pixel decode ----------------
    always_comb begin
        active       = (state_q == ACTIVE) && !start;
        px_accept    = active && px_valid && (px_col <= last_col_q);
        px_bad       = active && px_valid && (px_col > last_col_q);

        accum_merged = accum_q;
        if (px_accept) accum_merged[px_col] = ~px_neg;

        // A flush that coincides with the row-completing pixel needs no extra drain write.
        row_done     = px_accept && (px_col == last_col_q);
        drain_write  = active && flush && !row_done && (row_open_q || px_accept);
        issue_write  = row_done || drain_write;
        write_addr   = px_accept ? px_waddr : last_addr_q;

        for (int i = 0; i < DATA_W; i++) begin
            col_mask[i] = (COL_W'(i) <= last_col_q);
        end
    end

    // ---------------- accumulator, write register, counter ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            // NOTE: the row accumulator is a plain register, so it is reset with everything else.
            last_col_q   <= '0;
            accum_q      <= '0;
            row_open_q   <= 1'b0;
            last_addr_q  <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rows_written <= '0;
            col_err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                last_col_q   <= last_col;
                accum_q      <= '0;
                row_open_q   <= 1'b0;
                rows_written <= '0;
                col_err      <= 1'b0;
            end else begin
                if (px_bad)    col_err     <= 1'b1;
                if (px_accept) last_addr_q <= px_waddr;
                if (issue_write) begin
                    wr_en        <= 1'b1;
                    wr_addr      <= write_addr;
                    wr_data      <= accum_merged & col_mask;
                    rows_written <= rows_written + ADDR_W'(1);
                    accum_q      <= '0;
                    row_open_q   <= 1'b0;
                end else begin
                    accum_q      <= accum_merged;
                    row_open_q   <= row_open_q | px_accept;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_row_packer.sv
// Directed and randomized bench for output_row_packer against a row-level reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_output_row_packer;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  last_col = '0;
    logic        px_valid = 1'b0;
    logic        px_neg = 1'b0;
    logic [3:0]  px_col = '0;
    logic [11:0] px_waddr = '0;
    logic        flush = 1'b0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic [11:0] rows_written;
    logic        col_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model: image phase (0 idle, 1 active, 2 drain, 3 done) and the row being built
    int m_phase, m_lc, m_npx, m_rows, m_laddr;
    bit m_cerr;
    bit m_bits[16];
    bit e_wr_en;
    int e_addr, e_data;

    int cyc = 0;
    int wr_cycles[$];

    output_row_packer dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .last_col     (last_col),
        .px_valid     (px_valid),
        .px_neg       (px_neg),
        .px_col       (px_col),
        .px_waddr     (px_waddr),
        .flush        (flush),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .busy         (busy),
        .done         (done),
        .rows_written (rows_written),
        .col_err      (col_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic model_clear_row();
        for (int i = 0; i < 16; i++) m_bits[i] = 1'b0;
        m_npx = 0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_lc = 0; m_rows = 0; m_laddr = 0; m_cerr = 1'b0;
        e_wr_en = 1'b0; e_addr = 0; e_data = 0;
        model_clear_row();
    endtask

    task automatic model_emit(input int addr);
        int word;
        word = 0;
        for (int i = 0; i <= m_lc; i++) word += int'(m_bits[i]) * (1 << i);
        e_wr_en = 1'b1;
        e_addr  = addr;
        e_data  = word;
        m_rows  = (m_rows + 1) % 4096;
        model_clear_row();
    endtask

    // what the DUT should show after the coming rising edge, given the current inputs
    task automatic model_step();
        int pc;
        pc = int'(px_col);
        e_wr_en = 1'b0;
        if (start) begin
            m_phase = 1; m_lc = int'(last_col); m_rows = 0; m_cerr = 1'b0;
            model_clear_row();
        end else begin
            case (m_phase)
                1: begin
                    if (px_valid) begin
                        if (pc <= m_lc) begin
                            m_bits[pc] = !px_neg;
                            m_npx++;
                            m_laddr = int'(px_waddr);
                            if (pc == m_lc) model_emit(m_laddr);
                        end else begin
                            m_cerr = 1'b1;
                        end
                    end
                    if (flush) begin
                        if (m_npx > 0) model_emit(m_laddr);
                        m_phase = 2;
                    end
                end
                2: m_phase = 3;
                3: m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 3);
        check("wr_en", wr_en, e_wr_en);
        check("rows_written", rows_written, m_rows);
        check("col_err", col_err, m_cerr);
        if (e_wr_en) begin
            check("wr_addr", wr_addr, e_addr);
            check("wr_data", wr_data, e_data);
        end
        if (wr_en === 1'b1) wr_cycles.push_back(cyc);
    endtask

    task automatic step(input bit s, input int lc, input bit pv, input bit pn,
                        input int pc, input int pa, input bit fl);
        start = s; last_col = 4'(lc); px_valid = pv; px_neg = pn;
        px_col = 4'(pc); px_waddr = 12'(pa); flush = fl;
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rows"}, rows_written, 0);
        check({tag, "_col_err"}, col_err, 0);
    endtask

    initial begin
        int lc, col, addr, n, pc;
        bit pv, fl, s;

        // 1: reset, then reset again mid-row
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_b = 1'b1;
        idle(1);
        step(1, 13, 0, 0, 0, 0, 0);
        check("start_busy", busy, 1);
        for (int c = 0; c < 5; c++) step(0, 0, 1, 0, c, 'h123, 0);
        #2 reset_b = 1'b0;
        #1 check_all_zero("midrow_reset");
        model_reset();
        @(negedge clk);
        reset_b = 1'b1;
        step(1, 3, 0, 0, 0, 0, 0);
        check("restart_busy", busy, 1);
        step(0, 0, 1, 1, 3, 'h7, 0);
        check("after_reset_row", wr_data, 16'h0000);

        // 2: full row of 14 alternating pixels
        step(1, 13, 0, 0, 0, 0, 0);
        for (int c = 0; c <= 13; c++) step(0, 0, 1, c % 2, c, 'h040, 0);
        check("row_wr_en", wr_en, 1);
        check("row_wr_addr", wr_addr, 12'h040);
        check("row_wr_data", wr_data, 16'h1555);

        // 3: back-to-back rows
        step(1, 13, 0, 0, 0, 0, 0);
        wr_cycles.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c <= 13; c++) step(0, 0, 1, $urandom_range(0, 1), c, 'h040 + r, 0);
        idle(2);
        check("b2b_writes", wr_cycles.size(), 2);
        if (wr_cycles.size() == 2) check("b2b_gap", wr_cycles[1] - wr_cycles[0], 14);
        check("b2b_rows", rows_written, 2);

        // 4: partial flush in the same cycle as column 5
        step(1, 13, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) step(0, 0, 1, 0, c, 'h055, 0);
        step(0, 0, 1, 0, 5, 'h055, 1);
        check("drain_wr_en", wr_en, 1);
        check("drain_wr_data", wr_data, 16'h003F);
        check("drain_done_early", done, 0);
        idle(1);
        check("drain_done", done, 1);
        idle(1);
        check("drain_idle", busy, 0);

        // 5: out-of-range column
        step(1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 9, 'h010, 0);
        check("bad_col_err", col_err, 1);
        for (int c = 0; c <= 7; c++) step(0, 0, 1, 0, c, 'h010, 0);
        check("bad_col_data", wr_data, 16'h00FF);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        check("bad_col_sticky", col_err, 1);
        step(1, 7, 0, 0, 0, 0, 0);
        check("bad_col_cleared", col_err, 0);

        // 6: empty flush right after a row write, then abandon an image with start
        step(1, 13, 0, 0, 0, 0, 0);
        for (int c = 0; c <= 13; c++) step(0, 0, 1, 1, c, 'h200, 0);
        wr_cycles.delete();
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("empty_flush_done", done, 1);
        check("empty_flush_writes", wr_cycles.size(), 0);
        step(1, 13, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) step(0, 0, 1, 0, c, 'h300, 0);
        step(1, 13, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        check("abandon_writes", wr_cycles.size(), 0);
        check("abandon_rows", rows_written, 0);

        // randomized images
        for (int img = 0; img < 40; img++) begin
            lc = $urandom_range(0, 15);
            addr = $urandom_range(0, 4095);
            col = 0;
            step(1, lc, 0, 0, 0, 0, 0);
            n = $urandom_range(20, 120);
            for (int k = 0; k < n; k++) begin
                pv = ($urandom_range(0, 3) != 0);
                pc = col;
                if ($urandom_range(0, 9) == 0) pc = $urandom_range(0, 15);
                fl = (k == n - 1) || ($urandom_range(0, 59) == 0);
                s  = ($urandom_range(0, 99) == 0);
                if (s) begin
                    lc = $urandom_range(0, 15);
                    col = 0;
                end
                step(s, lc, pv, $urandom_range(0, 1), pc, addr, fl);
                if (!s && pv && pc == col) begin
                    if (col >= lc) begin
                        col = 0;
                        addr = (addr + 1) % 4096;
                    end else begin
                        col++;
                    end
                end
            end
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
